switch_allocator: RTL and testbench

- Per-router wormhole switch allocator. Shares each crossbar output port among the router's input units.
- Each input unit raises a switch request carrying its routed destination port. The allocator grants one input per free output with a round-robin policy, then drives the crossbar select.
- The grant is held (wormhole lock) until that input reports its tail flit has traversed. It sits between the input units' request/ack handshake and the crossbar.

---
 rtl/switch_allocator.sv | 119 +++++++++++
 tb/tb_switch_allocator.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/switch_allocator.sv
// Wormhole switch allocator. Each output port runs an IDLE/LOCKED FSM and grants one requesting
// input by round-robin. The grant is held until that input's tail flit has crossed the switch.
module switch_allocator #(
    parameter int unsigned NUM_PORTS = 5,
    parameter int unsigned PORT_W    = $clog2(NUM_PORTS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS-1:0]          i_switch_req,
    input  logic [NUM_PORTS*PORT_W-1:0]   i_dest,
    input  logic [NUM_PORTS-1:0]          i_tail_sent,
    input  logic [NUM_PORTS-1:0]          i_out_free,
    output logic [NUM_PORTS-1:0]          o_switch_ack,
    output logic [NUM_PORTS*PORT_W-1:0]   o_xbar_sel,
    output logic [NUM_PORTS-1:0]          o_out_locked
);

    typedef enum logic {StIdle, StLocked} state_e;

    state_e            r_state      [NUM_PORTS];
    state_e            w_state_next [NUM_PORTS];
    logic [PORT_W-1:0] r_owner      [NUM_PORTS];
    logic [PORT_W-1:0] w_owner_next [NUM_PORTS];
    logic [PORT_W-1:0] r_rr         [NUM_PORTS];
    logic [PORT_W-1:0] w_rr_next    [NUM_PORTS];

    logic [PORT_W-1:0]    w_dest   [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_cand   [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_found;
    logic [PORT_W-1:0]    w_winner [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_ack;

    // Out-of-range destinations never compare equal to a real output, so they are dropped here.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_dest[i] = i_dest[i*PORT_W +: PORT_W];
        end
        for (int o = 0; o < NUM_PORTS; o++) begin
            w_cand[o] = '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                w_cand[o][i] = i_switch_req[i] && (w_dest[i] == PORT_W'(o)) && !w_ack[i];
            end
        end
    end

    // Round-robin search starting at the pointer, wrapping modulo NUM_PORTS.
    always_comb begin
        logic [PORT_W-1:0] idx;
        idx = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            w_found[o]  = 1'b0;
            w_winner[o] = '0;
            for (int k = 0; k < NUM_PORTS; k++) begin
                idx = PORT_W'((32'(r_rr[o]) + 32'(k)) % NUM_PORTS);
                if (!w_found[o] && w_cand[o][idx]) begin
                    w_found[o]  = 1'b1;
                    w_winner[o] = idx;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (reset) begin
                r_state[o] <= StIdle;
                r_owner[o] <= '0;
                r_rr[o]    <= '0;
            end else begin
                r_state[o] <= w_state_next[o];
                r_owner[o] <= w_owner_next[o];
                r_rr[o]    <= w_rr_next[o];
            end
        end
    end

    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            w_state_next[o] = r_state[o];
            w_owner_next[o] = r_owner[o];
            w_rr_next[o]    = r_rr[o];
            unique case (r_state[o])
                StIdle: begin
                    if (i_out_free[o] && w_found[o]) begin
                        w_state_next[o] = StLocked;
                        w_owner_next[o] = w_winner[o];
                        w_rr_next[o]    = PORT_W'((32'(w_winner[o]) + 32'd1) % NUM_PORTS);
                    end
                end
                StLocked: begin
                    if (i_tail_sent[r_owner[o]]) begin
                        w_state_next[o] = StIdle;
                    end
                end
                default: w_state_next[o] = StIdle;
            endcase
        end
    end

    // Outputs depend only on registered state; sel keeps the last owner after release.
    always_comb begin
        w_ack        = '0;
        o_xbar_sel   = '0;
        o_out_locked = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            o_out_locked[o]                 = (r_state[o] == StLocked);
            o_xbar_sel[o*PORT_W +: PORT_W]  = r_owner[o];
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (r_state[o] == StLocked && r_owner[o] == PORT_W'(i)) begin
                    w_ack[i] = 1'b1;
                end
            end
        end
        o_switch_ack = w_ack;
    end

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator: single grant, round-robin order, pointer wrap,
// blocked outputs, illegal destinations and mid-packet reset.
module tb_switch_allocator;

    localparam int unsigned NUM_PORTS = 5;
    localparam int unsigned PORT_W    = 3;

    logic                        clk;
    logic                        reset;
    logic [NUM_PORTS-1:0]        i_switch_req;
    logic [NUM_PORTS*PORT_W-1:0] i_dest;
    logic [NUM_PORTS-1:0]        i_tail_sent;
    logic [NUM_PORTS-1:0]        i_out_free;
    logic [NUM_PORTS-1:0]        o_switch_ack;
    logic [NUM_PORTS*PORT_W-1:0] o_xbar_sel;
    logic [NUM_PORTS-1:0]        o_out_locked;

    logic [PORT_W-1:0] dest_a [NUM_PORTS];
    int n_checks = 0;
    int n_errors = 0;

    switch_allocator #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_W    (PORT_W)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .i_switch_req (i_switch_req),
        .i_dest       (i_dest),
        .i_tail_sent  (i_tail_sent),
        .i_out_free   (i_out_free),
        .o_switch_ack (o_switch_ack),
        .o_xbar_sel   (o_xbar_sel),
        .o_out_locked (o_out_locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        i_dest = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            i_dest[i*PORT_W +: PORT_W] = dest_a[i];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then settle so registered outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PORT_W-1:0] sel_of(input int o);
        return o_xbar_sel[o*PORT_W +: PORT_W];
    endfunction

    initial begin
        int exp_w [4];
        exp_w = '{0, 2, 3, 0};
        reset        = 1'b1;
        i_switch_req = '0;
        i_tail_sent  = '0;
        i_out_free   = '1;
        for (int i = 0; i < NUM_PORTS; i++) dest_a[i] = '0;
        step();
        step();
        reset = 1'b0;
        check_eq("rst_ack", 32'(o_switch_ack), 32'h0);
        check_eq("rst_locked", 32'(o_out_locked), 32'h0);
        check_eq("rst_sel", 32'(o_xbar_sel), 32'h0);

        // Single request: input 4 -> output 1
        i_switch_req = 5'b10000;
        dest_a[4]    = 3'd1;
        step();
        check_eq("single_ack", 32'(o_switch_ack), 32'h10);
        check_eq("single_sel1", 32'(sel_of(1)), 32'd4);
        check_eq("single_locked", 32'(o_out_locked), 32'h02);
        i_tail_sent  = 5'b10000;
        i_switch_req = '0;
        step();
        i_tail_sent = '0;
        check_eq("single_rel_ack", 32'(o_switch_ack), 32'h0);
        check_eq("single_rel_locked", 32'(o_out_locked), 32'h0);
        check_eq("single_sel_kept", 32'(sel_of(1)), 32'd4);

        // Round-robin on output 2 among inputs 0, 2, 3
        dest_a[0] = 3'd2;
        dest_a[2] = 3'd2;
        dest_a[3] = 3'd2;
        i_switch_req = 5'b01101;
        for (int g = 0; g < 4; g++) begin
            step();
            check_eq($sformatf("rr%0d_ack", g), 32'(o_switch_ack), 32'(5'b1 << exp_w[g]));
            check_eq($sformatf("rr%0d_sel2", g), 32'(sel_of(2)), 32'(exp_w[g]));
            check_eq($sformatf("rr%0d_locked", g), 32'(o_out_locked), 32'h04);
            step();
            step();
            i_tail_sent = 5'b1 << exp_w[g];
            step();
            i_tail_sent = '0;
            check_eq($sformatf("rr%0d_bubble", g), 32'(o_out_locked), 32'h0);
        end
        i_switch_req = '0;

        // Wrap and stale tails on output 0: set rr_ptr to 4 by granting input 3 first
        dest_a[3]    = 3'd0;
        i_switch_req = 5'b01000;
        step();
        check_eq("wrap_pre_ack", 32'(o_switch_ack), 32'h08);
        i_tail_sent  = 5'b01000;
        i_switch_req = '0;
        step();
        i_tail_sent  = '0;
        dest_a[1]    = 3'd0;
        dest_a[4]    = 3'd0;
        i_switch_req = 5'b10010;
        step();
        check_eq("wrap_sel0_4", 32'(sel_of(0)), 32'd4);
        check_eq("wrap_ack_4", 32'(o_switch_ack), 32'h10);
        i_tail_sent = 5'b00010;
        step();
        i_tail_sent = '0;
        check_eq("stale_tail_locked", 32'(o_out_locked[0]), 32'd1);
        check_eq("stale_tail_sel0", 32'(sel_of(0)), 32'd4);
        i_tail_sent  = 5'b10000;
        i_switch_req = 5'b00010;
        step();
        i_tail_sent = '0;
        check_eq("wrap_rel", 32'(o_out_locked[0]), 32'd0);
        step();
        check_eq("wrap_sel0_1", 32'(sel_of(0)), 32'd1);
        check_eq("wrap_ack_1", 32'(o_switch_ack), 32'h02);
        i_tail_sent  = 5'b00010;
        i_switch_req = '0;
        step();
        i_tail_sent = '0;

        // Parallel grants with output 3 blocked
        dest_a[0]    = 3'd3;
        dest_a[1]    = 3'd2;
        i_out_free   = 5'b00100;
        i_switch_req = 5'b00011;
        step();
        check_eq("par_ack", 32'(o_switch_ack), 32'h02);
        check_eq("par_locked", 32'(o_out_locked), 32'h04);
        i_out_free = 5'b01100;
        step();
        check_eq("par_free_ack", 32'(o_switch_ack), 32'h03);
        check_eq("par_free_locked", 32'(o_out_locked), 32'h0c);
        check_eq("par_sel3", 32'(sel_of(3)), 32'd0);
        i_tail_sent  = 5'b00011;
        i_switch_req = '0;
        i_out_free   = '1;
        step();
        i_tail_sent = '0;
        check_eq("par_rel", 32'(o_out_locked), 32'h0);

        // Illegal destination
        dest_a[2]    = 3'd6;
        i_switch_req = 5'b00100;
        step();
        step();
        step();
        check_eq("illegal_ack", 32'(o_switch_ack), 32'h0);
        check_eq("illegal_locked", 32'(o_out_locked), 32'h0);
        i_switch_req = '0;

        // Mid-packet reset while input 3 owns output 0
        dest_a[3]    = 3'd0;
        i_switch_req = 5'b01000;
        step();
        check_eq("pre_rst_sel0", 32'(sel_of(0)), 32'd3);
        check_eq("pre_rst_locked", 32'(o_out_locked), 32'h01);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("mid_rst_ack", 32'(o_switch_ack), 32'h0);
        check_eq("mid_rst_locked", 32'(o_out_locked), 32'h0);
        check_eq("mid_rst_sel", 32'(o_xbar_sel), 32'h0);
        // rr_ptr back at 0, so input 1 beats input 4 (without reset 4 would win)
        dest_a[1]    = 3'd0;
        dest_a[4]    = 3'd0;
        i_switch_req = 5'b10010;
        step();
        check_eq("post_rst_ack", 32'(o_switch_ack), 32'h02);
        check_eq("post_rst_sel0", 32'(sel_of(0)), 32'd1);
        i_switch_req = '0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
